// File: rtl/maze_walker_core.sv
// maze_walker_core: debounced one-hot player movement over a wall map queried with
// one-cycle latency; blocks walls and grid edges, counts moves, latches the win.
module maze_walker_core #(
   parameter int GRID_W   = 8,
   parameter int GRID_H   = 8,
   parameter int DEBOUNCE = 4,
   parameter int MOVE_W   = 8,
   parameter int GOAL_X   = GRID_W - 1,
   parameter int GOAL_Y   = GRID_H - 1
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        ena,
   input  logic                        restart,
   input  logic [3:0]                  dir_in,
   output logic                        map_req,
   output logic [$clog2(GRID_W)-1:0]   map_x,
   output logic [$clog2(GRID_H)-1:0]   map_y,
   input  logic [3:0]                  map_walls,
   output logic [$clog2(GRID_W)-1:0]   pos_x,
   output logic [$clog2(GRID_H)-1:0]   pos_y,
   output logic [MOVE_W-1:0]           moves,
   output logic                        bump,
   output logic                        won
);
   localparam int XW = $clog2(GRID_W);
   localparam int YW = $clog2(GRID_H);
   typedef enum logic [2:0] {IDLE, DEB, LOOK, WAIT, REL, WON} state_t;
   state_t         state;
   logic [3:0]     dir_cap;
   logic [7:0]     cnt;
   logic           at_edge;
   logic           blocked;
   logic [XW-1:0]  nx;
   logic [YW-1:0]  ny;
   assign map_x = pos_x;
   assign map_y = pos_y;
   // dir bits {left,down,right,up} line up with wall bits {W,S,E,N}
   always_comb begin
      at_edge = (dir_cap[0] && pos_y == '0) || (dir_cap[1] && pos_x == XW'(GRID_W - 1)) ||
                (dir_cap[2] && pos_y == YW'(GRID_H - 1)) || (dir_cap[3] && pos_x == '0);
      blocked = at_edge || |(map_walls & dir_cap);
      nx = dir_cap[1] ? pos_x + XW'(1) : dir_cap[3] ? pos_x - XW'(1) : pos_x;
      ny = dir_cap[2] ? pos_y + YW'(1) : dir_cap[0] ? pos_y - YW'(1) : pos_y;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         dir_cap <= '0;
         cnt     <= '0;
         pos_x   <= '0;
         pos_y   <= '0;
         moves   <= '0;
         bump    <= 1'b0;
         won     <= 1'b0;
         map_req <= 1'b0;
      end else if (restart) begin
         state   <= IDLE;
         dir_cap <= '0;
         cnt     <= '0;
         pos_x   <= '0;
         pos_y   <= '0;
         moves   <= '0;
         bump    <= 1'b0;
         won     <= 1'b0;
         map_req <= 1'b0;
      end else begin
         map_req <= 1'b0;
         bump    <= 1'b0;
         case (state)
            IDLE: if (ena && $onehot(dir_in)) begin
               dir_cap <= dir_in;
               cnt     <= '0;
               state   <= DEB;
            end
            DEB: if (dir_in != dir_cap) state <= IDLE;
               else if (cnt == 8'(DEBOUNCE - 1)) begin
                  state   <= LOOK;
                  map_req <= 1'b1;
               end else cnt <= cnt + 8'd1;
            LOOK: state <= WAIT;
            WAIT: if (blocked) begin
               bump  <= 1'b1;
               state <= REL;
            end else begin
               pos_x <= nx;
               pos_y <= ny;
               moves <= &moves ? moves : moves + MOVE_W'(1);
               won   <= nx == XW'(GOAL_X) && ny == YW'(GOAL_Y);
               state <= (nx == XW'(GOAL_X) && ny == YW'(GOAL_Y)) ? WON : REL;
            end
            REL: if (dir_in == 4'd0) state <= IDLE;
            WON: state <= WON;
            default: state <= IDLE;
         endcase
      end
   end
endmodule
